// File: rtl/dbg_reg_monitor.sv
// dbg_reg_monitor: run control (free-run / pause / single-step) plus a frozen
// register snapshot shown byte-lane by byte-lane on a narrow display bus.
// Optional breakpoint comparator is built when MON_BREAKPOINT_EN is defined.
module dbg_reg_monitor #(
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned REG_W     = 16,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned LANE_HOLD = 4,
  parameter int unsigned SEL_W     = $clog2(NUM_REGS),
  localparam int unsigned NLANES   = (REG_W + OUT_W - 1) / OUT_W,
  localparam int unsigned LANE_W   = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REGS*REG_W-1:0] regs_i,
  input  logic [SEL_W-1:0]          reg_sel_i,
  input  logic                      pause_i,
  input  logic                      step_i,
  input  logic [REG_W-1:0]          bp_value_i,
  input  logic                      bp_arm_i,
  output logic                      core_en_o,
  output logic [OUT_W-1:0]          disp_o,
  output logic [LANE_W-1:0]         lane_o,
  output logic                      bp_hit_o
);

  localparam int unsigned HOLD_W = (LANE_HOLD > 1) ? $clog2(LANE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LANE_HOLD - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NLANES - 1);

  typedef enum logic [1:0] {RUN, PAUSED, STEP, SETTLE} state_e;

  state_e                      state_q;
  logic                        pause_m_q, pause_s_q;
  logic                        step_m_q, step_s_q, step_d_q;
  logic                        pause_eff, step_edge, bp_hit;
  logic [NUM_REGS*REG_W-1:0]   snap_q, snap_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic [HOLD_W-1:0]           hold_q, hold_d;
  logic [LANE_W-1:0]           lane_q, lane_d;
  logic [OUT_W-1:0]            disp_q, disp_d;
  logic [LANE_W-1:0]           lane_out_q, lane_out_d;
  logic [REG_W-1:0]            sel_reg;
  logic [NLANES*OUT_W-1:0]     lane_ext;

  // Two-stage synchronisers for the asynchronous pause/step pins, plus step edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_m_q <= 1'b0;
      pause_s_q <= 1'b0;
      step_m_q  <= 1'b0;
      step_s_q  <= 1'b0;
      step_d_q  <= 1'b0;
    end else begin
      pause_m_q <= pause_i;
      pause_s_q <= pause_m_q;
      step_m_q  <= step_i;
      step_s_q  <= step_m_q;
      step_d_q  <= step_s_q;
    end
  end

  assign pause_eff = pause_s_q | bp_hit;
  assign step_edge = step_s_q & ~step_d_q;

  // Run-control FSM; a step edge outranks a simultaneous pause release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (pause_eff) state_q <= PAUSED;
        PAUSED:  if (step_edge) state_q <= STEP;
                 else if (!pause_eff) state_q <= RUN;
        STEP:    state_q <= SETTLE;
        SETTLE:  state_q <= PAUSED;
        default: state_q <= RUN;
      endcase
    end
  end

  assign core_en_o = (state_q == RUN) || (state_q == STEP);

  // Snapshot, select register and lane rotation next-state
  always_comb begin
    snap_d = snap_q;
    if (state_q == RUN || state_q == SETTLE) snap_d = regs_i;

    sel_d  = reg_sel_i;
    hold_d = hold_q;
    lane_d = lane_q;
    if (reg_sel_i != sel_q) begin
      hold_d = '0;
      lane_d = '0;
    end else if (hold_q == HOLD_LAST) begin
      hold_d = '0;
      lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Display lane extraction; lane bits beyond REG_W and out-of-range selects read as zero
  always_comb begin
    sel_reg  = '0;
    lane_ext = '0;
    if (32'(sel_q) < NUM_REGS) sel_reg = snap_q[32'(sel_q)*REG_W +: REG_W];
    lane_ext[REG_W-1:0] = sel_reg;
    disp_d     = lane_ext[32'(lane_q)*OUT_W +: OUT_W];
    lane_out_d = lane_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q     <= '0;
      sel_q      <= '0;
      hold_q     <= '0;
      lane_q     <= '0;
      disp_q     <= '0;
      lane_out_q <= '0;
    end else begin
      snap_q     <= snap_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      lane_q     <= lane_d;
      disp_q     <= disp_d;
      lane_out_q <= lane_out_d;
    end
  end

  assign disp_o = disp_q;
  assign lane_o = lane_out_q;

`ifdef MON_BREAKPOINT_EN
  logic arm_m_q, arm_s_q;
  logic bp_hit_q, bp_hit_d;
  logic bp_match;

  // Breakpoint compare on live registers, only while free-running so a step cannot re-hit
  always_comb begin
    bp_match = 1'b0;
    if (32'(sel_q) < NUM_REGS)
      bp_match = (regs_i[32'(sel_q)*REG_W +: REG_W] == bp_value_i);
    bp_hit_d = bp_hit_q;
    if (!arm_s_q) bp_hit_d = 1'b0;
    else if (state_q == RUN && bp_match) bp_hit_d = 1'b1;
  end

  // Arm synchroniser and sticky hit flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_m_q  <= 1'b0;
      arm_s_q  <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      arm_m_q  <= bp_arm_i;
      arm_s_q  <= arm_m_q;
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_value_i, bp_arm_i};
  assign bp_hit    = 1'b0;
`endif

  assign bp_hit_o = bp_hit;

endmodule
